reset_req_sequencer: RTL and testbench

Fast-clock-domain controller that shares the fast-to-slow reset synchronizer among several requesters. Each requester posts a single-cycle reset request. The block arbitrates round-robin and issues one single-cycle reset pulse to the synchronizer. It then tracks the synchronizer's slow-domain reset output back through a 2-flop synchronizer and reports completion or timeout per requester. It sits between the PCI-side command and control logic and the reset synchronizer instance.

---
 rtl/reset_req_sequencer_if.sv | 25 ++
 rtl/reset_req_sequencer.sv | 133 +++++++++++++
 tb/tb_reset_req_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_req_sequencer_if.sv
// Request/acknowledge bundle between the requesters, the reset sequencer and
// the shared fast-to-slow reset synchronizer.
interface reset_req_sequencer_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req;
  logic            rst_pulse;
  logic            rst_ack;
  logic            busy;
  logic [NREQ-1:0] pending;
  logic            done;
  logic            timeout;
  logic [IDW-1:0]  done_id;

  modport master (
    output req, rst_ack,
    input  rst_pulse, busy, pending, done, timeout, done_id
  );

  modport slave (
    input  req, rst_ack,
    output rst_pulse, busy, pending, done, timeout, done_id
  );
endinterface

// File: rtl/reset_req_sequencer.sv
// Round-robin sharing of one reset synchronizer among NREQ requesters: one
// reset pulse per granted request, completion or timeout reported per ID.
//
// state   | meaning
// IDLE    | no sequence in flight; grant when something is pending and ack is low
// ISSUE   | rst_pulse high for this single cycle; timer cleared
// WAIT_HI | waiting for the synchronized ack to rise
// WAIT_LO | waiting for the synchronized ack to fall
// FIN     | done pulse for cur_id
module reset_req_sequencer #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TOW     = 10,
  parameter int TIMEOUT = 1023
) (
  input logic                  fast_clk,
  input logic                  clr,
  reset_req_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, FIN} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] pending, grant_clr;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]  cur_id, cur_id_nxt, cur_id_inc;
  logic [IDW-1:0]  done_id, done_id_nxt;
  logic [TOW-1:0]  timer, timer_nxt;
  logic            ack_m, ack_s;
  logic            rst_pulse, rst_pulse_nxt;
  logic            done, done_nxt;
  logic            timeout, timeout_nxt;
  logic            win_vld;
  logic [IDW-1:0]  win_id;

  always_comb begin : arb
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_vld && pending[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign cur_id_inc = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);

  always_comb begin : fsm
    state_nxt     = state;
    cur_id_nxt    = cur_id;
    rr_ptr_nxt    = rr_ptr;
    done_id_nxt   = done_id;
    timer_nxt     = timer;
    rst_pulse_nxt = 1'b0;
    done_nxt      = 1'b0;
    timeout_nxt   = 1'b0;
    grant_clr     = '0;
    case (state)
      IDLE: begin
        // never re-pulse while the previous ack is still visible
        if (win_vld && !ack_s) begin
          state_nxt         = ISSUE;
          cur_id_nxt        = win_id;
          grant_clr[win_id] = 1'b1;
          rst_pulse_nxt     = 1'b1;
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI, WAIT_LO: begin
        timer_nxt = timer + TOW'(1);
        if (timer == TOW'(TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          done_id_nxt = cur_id;
          rr_ptr_nxt  = cur_id_inc;
          state_nxt   = IDLE;
        end else if (state == WAIT_HI && ack_s) begin
          state_nxt = WAIT_LO;
        end else if (state == WAIT_LO && !ack_s) begin
          done_nxt    = 1'b1;
          done_id_nxt = cur_id;
          rr_ptr_nxt  = cur_id_inc;
          state_nxt   = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (clr) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      cur_id    <= '0;
      done_id   <= '0;
      timer     <= '0;
      ack_m     <= 1'b0;
      ack_s     <= 1'b0;
      rst_pulse <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // a request landing on its own grant edge is re-queued
      pending   <= (pending & ~grant_clr) | bus.req;
      rr_ptr    <= rr_ptr_nxt;
      cur_id    <= cur_id_nxt;
      done_id   <= done_id_nxt;
      timer     <= timer_nxt;
      ack_m     <= bus.rst_ack;
      ack_s     <= ack_m;
      rst_pulse <= rst_pulse_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign bus.rst_pulse = rst_pulse;
  assign bus.busy      = (state != IDLE);
  assign bus.pending   = pending;
  assign bus.done      = done;
  assign bus.timeout   = timeout;
  assign bus.done_id   = done_id;

endmodule

// File: tb/tb_reset_req_sequencer.sv
// Scoreboard bench for reset_req_sequencer: a round-robin reference model
// predicts grant order and end kind; a slow-domain ack model answers pulses.
module tb_reset_req_sequencer;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TOW     = 10;
  localparam int TIMEOUT = 60;

  logic fast_clk = 1'b0;
  logic clr      = 1'b1;
  int   ack_mode = 0;   // 0 normal, 1 stuck low, 2 stuck high after pulse

  reset_req_sequencer_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  reset_req_sequencer #(.NREQ(NREQ), .IDW(IDW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
    .fast_clk (fast_clk),
    .clr      (clr),
    .bus      (bus)
  );

  initial forever #5 fast_clk = ~fast_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  typedef struct packed {logic is_to; logic [IDW-1:0] id;} exp_t;
  exp_t            sbq[$];
  logic [IDW-1:0]  log_q[$];
  logic [NREQ-1:0] mp = '0;
  int rr = 0, grants = 0, comps = 0, n_merged = 0, max_wait = 0;
  int wait_cnt[NREQ];
  logic prev_pulse = 1'b0;

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int start);
    for (int k = 0; k < NREQ; k++)
      if (p[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] log_pack();
    logic [31:0] v;
    v = '0;
    foreach (log_q[i]) v = (v << 4) | 32'(int'(log_q[i]) + 1);
    return v;
  endfunction

  // reference model and scoreboard, sampled just after each active edge
  initial begin
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    forever begin
      @(posedge fast_clk); #1;
      if (clr) begin
        sbq.delete();
        mp         = '0;
        rr         = 0;
        prev_pulse = 1'b0;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
      end else begin
        chk("dbl_pulse", 32'(bus.rst_pulse & prev_pulse), 0);
        prev_pulse = bus.rst_pulse;
        if (bus.rst_pulse) begin
          int   w;
          exp_t ne;
          w = rr_pick(mp, rr);
          chk("one_flight", sbq.size(), 0);
          if (w < 0) chk("grant_no_req", 1, 0);
          else begin
            for (int i = 0; i < NREQ; i++)
              if (i != w && mp[i]) begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
              end
            wait_cnt[w] = 0;
            ne.is_to = (ack_mode != 0);
            ne.id    = IDW'(w);
            sbq.push_back(ne);
            mp[w] = 1'b0;
            grants++;
          end
        end
        for (int i = 0; i < NREQ; i++)
          if (bus.req[i] && !mp[i]) begin
            mp[i] = 1'b1;
            n_merged++;
          end
        chk("pending", bus.pending, mp);
        if (bus.done || bus.timeout) begin
          log_q.push_back(bus.done_id);
          if (sbq.size() == 0) chk("unexp_end", {bus.timeout, bus.done}, 0);
          else begin
            exp_t e;
            e = sbq.pop_front();
            chk("end_kind_id", {bus.timeout, bus.done, bus.done_id}, {e.is_to, ~e.is_to, e.id});
            rr = (int'(e.id) + 1) % NREQ;
            comps++;
          end
        end
      end
    end
  end

  // slow-domain synchronizer model: 8 fast cycles per slow period
  initial begin
    int div, hi_cnt;
    bit armed, seq_hi;
    div = 0; hi_cnt = 0; armed = 0; seq_hi = 0;
    bus.rst_ack = 1'b0;
    forever begin
      @(negedge fast_clk);
      div = (div + 1) % 8;
      case (ack_mode)
        0: begin
          if (bus.rst_ack && !seq_hi) bus.rst_ack = 1'b0;
          if (bus.rst_pulse) armed = 1;
          if (div == 0) begin
            if (bus.rst_ack) begin
              if (hi_cnt == 1) begin bus.rst_ack = 1'b0; seq_hi = 0; end
              else hi_cnt++;
            end else if (armed) begin
              bus.rst_ack = 1'b1; seq_hi = 1; armed = 0; hi_cnt = 0;
            end
          end
        end
        1: begin bus.rst_ack = 1'b0; armed = 0; seq_hi = 0; end
        default: begin
          seq_hi = 0; armed = 0;
          if (bus.rst_pulse) bus.rst_ack = 1'b1;
        end
      endcase
    end
  end

  task automatic pulse_req(input logic [NREQ-1:0] v);
    @(negedge fast_clk); bus.req = v;
    @(negedge fast_clk); bus.req = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus.busy || bus.pending != 0 || sbq.size() != 0) && n < 400) begin
      @(negedge fast_clk); n++;
    end
    chk(tag, 32'(n < 400), 1);
    repeat (2) @(negedge fast_clk);
  endtask

  initial begin
    int n, m0, c0;
    logic bad;
    bus.req = '0;
    clr     = 1'b1;
    repeat (3) @(negedge fast_clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pend", bus.pending, 0);
    chk("rst_outs", {bus.rst_pulse, bus.done, bus.timeout, bus.done_id}, 0);
    clr = 1'b0;

    // single request: pulse two cycles after req, one cycle wide
    pulse_req(4'b0001);
    chk("t1_pend", bus.pending, 4'b0001);
    chk("t1_no_early", bus.rst_pulse, 0);
    @(negedge fast_clk);
    chk("t1_pulse", bus.rst_pulse, 1);
    @(negedge fast_clk);
    chk("t1_pulse_width", bus.rst_pulse, 0);
    chk("t1_busy", bus.busy, 1);
    wait_idle("t1_idle");
    chk("t1_order", log_pack(), 32'h1);
    chk("t1_busy_after", bus.busy, 0);
    log_q.delete();

    // contention
    pulse_req(4'b1010);
    wait_idle("t2a_idle");
    chk("t2_order_1_3", log_pack(), 32'h24);
    log_q.delete();
    pulse_req(4'b1011);
    wait_idle("t2b_idle");
    chk("t2_order_0_1_3", log_pack(), 32'h124);
    log_q.delete();

    // re-request while ID2 is in service
    pulse_req(4'b0100);
    @(negedge fast_clk);
    chk("t3_pulse", bus.rst_pulse, 1);
    pulse_req(4'b0100);
    chk("t3_pend_svc", bus.pending, 4'b0100);
    chk("t3_busy", bus.busy, 1);
    wait_idle("t3a_idle");
    chk("t3_order_2_2", log_pack(), 32'h33);
    log_q.delete();
    // request on the grant edge itself is re-queued
    @(negedge fast_clk); bus.req = 4'b0100;
    @(negedge fast_clk); bus.req = 4'b0100;
    @(negedge fast_clk); bus.req = '0;
    chk("t3_grant_pulse", bus.rst_pulse, 1);
    chk("t3_requeue", bus.pending, 4'b0100);
    wait_idle("t3b_idle");
    chk("t3b_order_2_2", log_pack(), 32'h33);
    log_q.delete();

    // clr mid WAIT_LO
    pulse_req(4'b0001);
    @(negedge fast_clk);
    pulse_req(4'b0110);
    n = 0;
    while (!bus.rst_ack && n < 40) begin @(posedge fast_clk); n++; end
    chk("t5_ack_seen", bus.rst_ack, 1);
    repeat (4) @(negedge fast_clk);
    chk("t5_pend_pre", bus.pending, 4'b0110);
    clr = 1'b1;
    @(negedge fast_clk);
    clr = 1'b0;
    chk("t5_outs", {bus.rst_pulse, bus.done, bus.timeout, bus.busy, bus.done_id}, 0);
    chk("t5_pend", bus.pending, 0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge fast_clk);
      bad |= bus.rst_pulse | bus.done | bus.timeout | bus.busy;
    end
    chk("t5_quiet", bad, 0);
    log_q.delete();
    pulse_req(4'b0100);
    wait_idle("t5_idle");
    chk("t5_fresh", log_pack(), 32'h3);
    log_q.delete();

    // timeout with ack stuck low
    @(negedge fast_clk); ack_mode = 1;
    pulse_req(4'b0001);
    @(negedge fast_clk);
    chk("t4_pulse", bus.rst_pulse, 1);
    n = 0; bad = 1'b0;
    do begin
      @(negedge fast_clk); n++;
      bad |= bus.done;
    end while (!bus.timeout && n < TIMEOUT + 20);
    chk("t4_to_latency", n, TIMEOUT + 1);
    chk("t4_to_id", bus.done_id, 0);
    chk("t4_no_done", bad, 0);
    @(negedge fast_clk);
    chk("t4_busy_after", bus.busy, 0);
    chk("t4_to_width", bus.timeout, 0);

    // timeout in WAIT_LO with ack stuck high, next issue held off
    @(negedge fast_clk); ack_mode = 2;
    pulse_req(4'b0001);
    n = 0;
    while (!bus.timeout && n < TIMEOUT + 20) begin @(negedge fast_clk); n++; end
    chk("t4b_timeout", bus.timeout, 1);
    chk("t4b_to_id", bus.done_id, 0);
    pulse_req(4'b0010);
    bad = 1'b0;
    repeat (10) begin @(negedge fast_clk); bad |= bus.rst_pulse; end
    chk("t4b_held", bad, 0);
    chk("t4b_pend", bus.pending, 4'b0010);
    @(posedge fast_clk); #2 ack_mode = 0;
    @(negedge fast_clk);
    @(negedge fast_clk); chk("t4b_rel_1", bus.rst_pulse, 0);
    @(negedge fast_clk); chk("t4b_rel_2", bus.rst_pulse, 0);
    @(negedge fast_clk); chk("t4b_rel_3", bus.rst_pulse, 1);
    wait_idle("t4b_idle");
    log_q.delete();

    // random stress
    m0 = n_merged;
    c0 = comps;
    max_wait = 0;
    repeat (10000) begin
      logic [NREQ-1:0] r;
      @(negedge fast_clk);
      for (int i = 0; i < NREQ; i++) r[i] = ($urandom_range(0, 7) == 0);
      bus.req = r;
    end
    @(negedge fast_clk); bus.req = '0;
    wait_idle("t6_drain");
    chk("t6_no_lost", comps - c0, n_merged - m0);
    chk("t6_starve", 32'(max_wait <= NREQ - 1), 1);
    chk("t6_activity", 32'(comps - c0 > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
